// File: rtl/manchester_byte_assembler_if.sv
// Bus between the Manchester bit decoder, the byte assembler and the byte consumer.
// master = decoder/consumer side, slave = the assembler.
interface manchester_byte_assembler_if #(
    parameter int unsigned COUNT_W = 8
);
    logic               frame_begin;
    logic               bit_strobe;
    logic               bit_data;
    logic [7:0]         byte_data;
    logic               byte_valid;
    logic               byte_ready;
    logic               frame_active;
    logic               frame_done;
    logic               frame_error;
    logic               overrun;
    logic [COUNT_W-1:0] frame_byte_count;

    modport master (
        output frame_begin, bit_strobe, bit_data, byte_ready,
        input  byte_data, byte_valid, frame_active, frame_done, frame_error,
               overrun, frame_byte_count
    );

    modport slave (
        input  frame_begin, bit_strobe, bit_data, byte_ready,
        output byte_data, byte_valid, frame_active, frame_done, frame_error,
               overrun, frame_byte_count
    );
endinterface

// File: rtl/manchester_byte_assembler.sv
// Packs decoded Manchester bits LSB-first into bytes behind a valid/ready holding register;
// ends frames on a bit-gap timeout. Optional CRC-8 frame check: MANCHESTER_BYTE_ASSEMBLER_CRC8_EN.
module manchester_byte_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned TIMER_W        = 6,
    parameter int unsigned COUNT_W        = 8
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    manchester_byte_assembler_if.slave    bus_io
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;
    localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

    typedef enum logic {
        ST_IDLE,
        ST_RECEIVE
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 overrun_q, overrun_d;
    logic [7:0]           hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 accept_c;
    logic                 crc_fail_c;
    logic [7:0]           new_byte_c;

`ifdef MANCHESTER_BYTE_ASSEMBLER_CRC8_EN
    logic [7:0]           crc_q, crc_d;

    // Bytes enter the CRC MSB-first, so a trailing CRC byte is the conventional CRC-8 of the payload.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign crc_fail_c = (crc_q != 8'h00);
`else
    assign crc_fail_c = 1'b0;
`endif

    assign accept_c   = hold_valid_q & bus_io.byte_ready;
    assign new_byte_c = {bus_io.bit_data, shift_q[6:0]};

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        timer_d      = timer_q;
        count_d      = count_q;
        overrun_d    = overrun_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
`ifdef MANCHESTER_BYTE_ASSEMBLER_CRC8_EN
        crc_d        = crc_q;
`endif

        if (accept_c) begin
            hold_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus_io.frame_begin) begin
                    state_d   = ST_RECEIVE;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    timer_d   = '0;
                    count_d   = '0;
                    overrun_d = 1'b0;
`ifdef MANCHESTER_BYTE_ASSEMBLER_CRC8_EN
                    crc_d     = '0;
`endif
                end
            end

            ST_RECEIVE: begin
                if (bus_io.frame_begin) begin
                    // Abort the current frame and restart; a coincident strobe is dropped.
                    done_d    = 1'b1;
                    error_d   = 1'b1;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    timer_d   = '0;
                    count_d   = '0;
                    overrun_d = 1'b0;
`ifdef MANCHESTER_BYTE_ASSEMBLER_CRC8_EN
                    crc_d     = '0;
`endif
                end else if (bus_io.bit_strobe) begin
                    shift_d[bit_cnt_q] = bus_io.bit_data;
                    bit_cnt_d          = 3'(bit_cnt_q + 3'd1);
                    timer_d            = '0;
                    if (bit_cnt_q == 3'd7) begin
                        if (count_q != COUNT_MAX) begin
                            count_d = COUNT_W'(count_q + 1'b1);
                        end
`ifdef MANCHESTER_BYTE_ASSEMBLER_CRC8_EN
                        crc_d = crc8_byte(crc_q, new_byte_c);
`endif
                        if (!hold_valid_q || accept_c) begin
                            hold_d       = new_byte_c;
                            hold_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else if (timer_q == TIMER_LAST) begin
                    done_d  = 1'b1;
                    error_d = (bit_cnt_q != 3'd0) || crc_fail_c;
                    state_d = ST_IDLE;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = TIMER_W'(timer_q + 1'b1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            timer_q      <= '0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef MANCHESTER_BYTE_ASSEMBLER_CRC8_EN
            crc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef MANCHESTER_BYTE_ASSEMBLER_CRC8_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign bus_io.byte_data        = hold_q;
    assign bus_io.byte_valid       = hold_valid_q;
    assign bus_io.frame_active     = (state_q == ST_RECEIVE);
    assign bus_io.frame_done       = done_q;
    assign bus_io.frame_error      = error_q;
    assign bus_io.overrun          = overrun_q;
    assign bus_io.frame_byte_count = count_q;

endmodule

// File: tb/tb_manchester_byte_assembler.sv
// Directed and randomized bench for manchester_byte_assembler; expectations come from
// frame-level rules (byte list, leftover bits, polynomial-division CRC).
module tb_manchester_byte_assembler;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] frame_q[$];

    manchester_byte_assembler_if #(.COUNT_W(8)) mba ();

    manchester_byte_assembler #(
        .TIMEOUT_CYCLES(40),
        .TIMER_W(6),
        .COUNT_W(8)
    ) dut (
        .clock_i(clk),
        .reset_i(rst),
        .bus_io (mba.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Remainder of M(x)*x^8 mod (x^8+x^2+x+1), message bytes taken MSB-first.
    function automatic logic [7:0] crc_remainder();
        logic [8:0] r;
        bit         bits[$];
        r = '0;
        foreach (frame_q[i]) for (int k = 7; k >= 0; k--) bits.push_back(frame_q[i][k]);
        for (int k = 0; k < 8; k++) bits.push_back(1'b0);
        foreach (bits[i]) begin
            r = {r[7:0], bits[i]};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic logic expected_error(input int extra_bits);
`ifdef MANCHESTER_BYTE_ASSEMBLER_CRC8_EN
        return (extra_bits != 0) || (crc_remainder() != 8'h00);
`else
        return (extra_bits != 0);
`endif
    endfunction

    task automatic pulse_begin();
        mba.frame_begin = 1'b1;
        tick();
        mba.frame_begin = 1'b0;
        frame_q.delete();
    endtask

    // period 0 = random gap of 1..20 clocks between strobes
    task automatic send_bit(input logic b, input int period, input bit last);
        int gap;
        mba.bit_strobe = 1'b1;
        mba.bit_data   = b;
        tick();
        mba.bit_strobe = 1'b0;
        mba.bit_data   = 1'($urandom);
        if (!last) begin
            gap = (period == 0) ? int'($urandom_range(1, 20)) : period;
            repeat (gap - 1) tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit check, input int period);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i], period, i == 7);
        end
        frame_q.push_back(b);
        if (check) begin
            chk("byte_valid_after_8th", 32'(mba.byte_valid), 32'd1);
            chk("byte_data_after_8th", 32'(mba.byte_data), 32'(b));
        end
    endtask

    task automatic send_bits(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            tick();
            send_bit(1'($urandom), period, 1'b1);
        end
    endtask

    task automatic wait_done(input string tag, input logic exp_err, input int exp_cnt);
        int n = 0;
        while (mba.frame_done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(mba.frame_done), 32'd1);
        chk({tag, "_error"}, 32'(mba.frame_error), 32'(exp_err));
        chk({tag, "_count"}, 32'(mba.frame_byte_count), 32'(exp_cnt));
        chk({tag, "_active"}, 32'(mba.frame_active), 32'd0);
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, 32'(mba.byte_data), 32'd0);
        chk({tag, "_valid"}, 32'(mba.byte_valid), 32'd0);
        chk({tag, "_active"}, 32'(mba.frame_active), 32'd0);
        chk({tag, "_done"}, 32'(mba.frame_done), 32'd0);
        chk({tag, "_error"}, 32'(mba.frame_error), 32'd0);
        chk({tag, "_overrun"}, 32'(mba.overrun), 32'd0);
        chk({tag, "_count"}, 32'(mba.frame_byte_count), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int         nb;
        int         extra;

        rst             = 1'b1;
        mba.frame_begin = 1'b0;
        mba.bit_strobe  = 1'b0;
        mba.bit_data    = 1'b0;
        mba.byte_ready  = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single byte 0xA5, exact latency and timeout position
        pulse_begin();
        chk("a5_active", 32'(mba.frame_active), 32'd1);
        send_byte(8'hA5, 1'b1, 18);
        tick();
        chk("a5_accepted", 32'(mba.byte_valid), 32'd0);
        repeat (38) tick();
        chk("a5_no_early_done", 32'(mba.frame_done), 32'd0);
        tick();
        chk("a5_done", 32'(mba.frame_done), 32'd1);
        chk("a5_error", 32'(mba.frame_error), 32'(expected_error(0)));
        chk("a5_count", 32'(mba.frame_byte_count), 32'd1);
        chk("a5_idle", 32'(mba.frame_active), 32'd0);
        tick();
        chk("a5_done_pulse", 32'(mba.frame_done), 32'd0);

        // Overrun with consumer stalled
        mba.byte_ready = 1'b0;
        pulse_begin();
        send_byte(8'h12, 1'b1, 18);
        repeat (17) tick();
        send_byte(8'h34, 1'b0, 18);
        chk("ovr_data_frozen", 32'(mba.byte_data), 32'h12);
        chk("ovr_valid", 32'(mba.byte_valid), 32'd1);
        chk("ovr_flag", 32'(mba.overrun), 32'd1);
        chk("ovr_count", 32'(mba.frame_byte_count), 32'd2);
        mba.byte_ready = 1'b1;
        tick();
        chk("ovr_accept", 32'(mba.byte_valid), 32'd0);
        chk("ovr_sticky", 32'(mba.overrun), 32'd1);
        wait_done("ovr", expected_error(0), 2);

        // 11 bits then timeout: partial byte
        pulse_begin();
        chk("partial_overrun_cleared", 32'(mba.overrun), 32'd0);
        b = 8'($urandom);
        send_byte(b, 1'b1, 18);
        send_bits(3, 18);
        wait_done("partial", 1'b1, 1);

        // Abort after 3 bits, with a strobe coincident with frame_begin
        pulse_begin();
        send_bits(3, 18);
        tick();
        mba.frame_begin = 1'b1;
        mba.bit_strobe  = 1'b1;
        mba.bit_data    = 1'b1;
        tick();
        mba.frame_begin = 1'b0;
        mba.bit_strobe  = 1'b0;
        frame_q.delete();
        chk("abort_done", 32'(mba.frame_done), 32'd1);
        chk("abort_error", 32'(mba.frame_error), 32'd1);
        chk("abort_active", 32'(mba.frame_active), 32'd1);
        chk("abort_count", 32'(mba.frame_byte_count), 32'd0);
        tick();
        chk("abort_done_pulse", 32'(mba.frame_done), 32'd0);
        send_byte(8'hFF, 1'b1, 18);
        chk("abort_count_after", 32'(mba.frame_byte_count), 32'd1);
        wait_done("abort_tail", expected_error(0), 1);

        // Reset mid-frame with a byte held
        mba.byte_ready = 1'b0;
        pulse_begin();
        send_byte(8'h5A, 1'b1, 18);
        tick();
        chk("rst_pre_valid", 32'(mba.byte_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rst_mid");
        mba.byte_ready = 1'b1;

        // Strobes in IDLE, and one coincident with frame_begin, are ignored
        frame_q.delete();
        for (int i = 0; i < 8; i++) send_bit(1'b1, 2, 1'b0);
        tick();
        chk("idle_ignore_valid", 32'(mba.byte_valid), 32'd0);
        chk("idle_ignore_active", 32'(mba.frame_active), 32'd0);
        mba.frame_begin = 1'b1;
        mba.bit_strobe  = 1'b1;
        mba.bit_data    = 1'b1;
        tick();
        mba.frame_begin = 1'b0;
        mba.bit_strobe  = 1'b0;
        frame_q.delete();
        tick();
        send_byte(8'h3C, 1'b1, 5);
        wait_done("idle_begin", expected_error(0), 1);

        // Randomized frames against the frame-level model
        for (int f = 0; f < 8; f++) begin
            pulse_begin();
            nb    = int'($urandom_range(1, 4));
            extra = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
            for (int k = 0; k < nb; k++) begin
                b = 8'($urandom);
`ifdef MANCHESTER_BYTE_ASSEMBLER_CRC8_EN
                if (k == nb - 1 && nb > 1 && f[0]) b = crc_remainder();
`endif
                if (k != 0) tick();
                send_byte(b, 1'b1, 0);
            end
            send_bits(extra, 0);
            wait_done("rand_frame", expected_error(extra), nb);
        end

        // CRC check: 0x07 is the CRC-8 of 0x01
        pulse_begin();
        send_byte(8'h01, 1'b1, 18);
        tick();
        send_byte(8'h07, 1'b1, 18);
        wait_done("crc_good", 1'b0, 2);
        pulse_begin();
        send_byte(8'h01, 1'b1, 18);
        tick();
        send_byte(8'h08, 1'b1, 18);
`ifdef MANCHESTER_BYTE_ASSEMBLER_CRC8_EN
        wait_done("crc_bad", 1'b1, 2);
`else
        wait_done("crc_bad", 1'b0, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
